// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results queue in a FIFO and
// drain on WB-idle cycles; a pending scoreboard stalls ID reads. Option: REGFILE_ARB_FULL_STALL_EN.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RegWrite_WB,
  input  logic [4:0]        Write_Register_WB,
  input  logic [DATA_W-1:0] Write_Data_WB,
  input  logic              MDU_Issue,
  input  logic [4:0]        MDU_Issue_Dest,
  input  logic              MDU_Valid,
  output logic              MDU_Ready,
  input  logic [4:0]        MDU_Result_Dest,
  input  logic [DATA_W-1:0] MDU_Result_Data,
  input  logic [4:0]        Read_Address_1_ID,
  input  logic [4:0]        Read_Address_2_ID,
  output logic              Stall_ID,
  output logic              RegWrite_RF,
  output logic [4:0]        Write_Register_RF,
  output logic [DATA_W-1:0] Write_Data_RF
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [4:0]        dest_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pending_q, pending_d;

  logic wb_sel, fifo_empty, fifo_full, accept, push, pop, stall_full;

  always_comb begin
    wb_sel     = RegWrite_WB && (Write_Register_WB != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    // Ready looks at the registered count only: no push-through while full.
    MDU_Ready  = Reset_n && !fifo_full;
    accept     = MDU_Valid && MDU_Ready;
    push       = accept && (MDU_Result_Dest != 5'd0);
    pop        = Reset_n && !wb_sel && !fifo_empty;
  end

  always_comb begin
    RegWrite_RF       = 1'b0;
    Write_Register_RF = 5'd0;
    Write_Data_RF     = '0;
    if (Reset_n) begin
      if (wb_sel) begin
        RegWrite_RF       = 1'b1;
        Write_Register_RF = Write_Register_WB;
        Write_Data_RF     = Write_Data_WB;
      end else if (!fifo_empty) begin
        RegWrite_RF       = 1'b1;
        Write_Register_RF = dest_mem_q[rd_ptr_q];
        Write_Data_RF     = data_mem_q[rd_ptr_q];
      end
    end
  end

`ifdef REGFILE_ARB_FULL_STALL_EN
  assign stall_full = fifo_full;
`else
  assign stall_full = 1'b0;
`endif

  assign Stall_ID = Reset_n &&
                    (pending_q[Read_Address_1_ID] || pending_q[Read_Address_2_ID] || stall_full);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      pending_d[dest_mem_q[rd_ptr_q]] = 1'b0;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Issue is applied after the pop clear so a same-cycle set wins.
    if (MDU_Issue && (MDU_Issue_Dest != 5'd0)) pending_d[MDU_Issue_Dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      dest_mem_q[wr_ptr_q] <= MDU_Result_Dest;
      data_mem_q[wr_ptr_q] <= MDU_Result_Data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        iss;
  logic [4:0]  iss_dest;
  logic        mvalid;
  logic        mready;
  logic [4:0]  mdest;
  logic [31:0] mdata;
  logic [4:0]  ra1, ra2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .Clk(clk), .Reset_n(rst_n),
    .RegWrite_WB(wb_we), .Write_Register_WB(wb_rd), .Write_Data_WB(wb_data),
    .MDU_Issue(iss), .MDU_Issue_Dest(iss_dest),
    .MDU_Valid(mvalid), .MDU_Ready(mready),
    .MDU_Result_Dest(mdest), .MDU_Result_Data(mdata),
    .Read_Address_1_ID(ra1), .Read_Address_2_ID(ra2),
    .Stall_ID(stall),
    .RegWrite_RF(rf_we), .Write_Register_RF(rf_rd), .Write_Data_RF(rf_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit   [31:0] m_pend;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model for the current inputs (mid-cycle).
  task automatic settle();
    bit          e_we, e_rdy, e_stall, wbsel;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    @(negedge clk);
    e_we = 0; e_rd = 0; e_data = 0; e_rdy = 0; e_stall = 0;
    if (rst_n) begin
      wbsel = wb_we && wb_rd != 0;
      if (wbsel) begin
        e_we = 1; e_rd = wb_rd; e_data = wb_data;
      end else if (m_q.size() > 0) begin
        e_we = 1; e_rd = m_q[0].dest; e_data = m_q[0].data;
      end
      e_rdy   = m_q.size() < DEPTH;
      e_stall = m_pend[ra1] || m_pend[ra2];
`ifdef REGFILE_ARB_FULL_STALL_EN
      if (m_q.size() == DEPTH) e_stall = 1;
`endif
    end
    chk("model_we", 32'(rf_we), 32'(e_we));
    chk("model_rd", 32'(rf_rd), 32'(e_rd));
    chk("model_data", rf_data, e_data);
    chk("model_ready", 32'(mready), 32'(e_rdy));
    chk("model_stall", 32'(stall), 32'(e_stall));
  endtask

  // Apply the posedge to the model, then let the DUT register.
  task automatic advance();
    ent_t h;
    bit   wbsel, rdy;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_pend = '0;
    end else begin
      wbsel = wb_we && wb_rd != 0;
      rdy   = m_q.size() < DEPTH;
      if (!wbsel && m_q.size() > 0) begin
        h = m_q.pop_front();
        m_pend[h.dest] = 0;
      end
      if (mvalid && rdy && mdest != 0) m_q.push_back('{dest: mdest, data: mdata});
      if (iss && iss_dest != 0) m_pend[iss_dest] = 1;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0; iss = 0; iss_dest = 0;
    mvalid = 0; mdest = 0; mdata = 0; ra1 = 0; ra2 = 0;
  endtask

  initial begin
    m_pend = '0;
    rst_n  = 0;
    idle_inputs();

    // Held in reset: everything quiet, including ready.
    settle();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_ready", 32'(mready), 0);
    chk("rst_stall", 32'(stall), 0);
    advance();
    cycle();

    // Idle after reset.
    rst_n = 1;
    settle();
    chk("idle_we", 32'(rf_we), 0);
    chk("idle_ready", 32'(mready), 1);
    chk("idle_stall", 32'(stall), 0);
    advance();

    // WB pass-through.
    wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
    settle();
    chk("wb_we", 32'(rf_we), 1);
    chk("wb_rd", 32'(rf_rd), 5);
    chk("wb_data", rf_data, 32'h1234);
    advance();
    idle_inputs();

    // MDU issue to $8, result at t3, RF write t4, stall low from t5.
    iss = 1; iss_dest = 8; ra1 = 8;
    cycle();                               // t0
    iss = 0;
    settle();                              // t1
    chk("mdu_stall_t1", 32'(stall), 1);
    advance();
    cycle();                               // t2
    mvalid = 1; mdest = 8; mdata = 32'hCAFE;
    settle();                              // t3
    chk("mdu_ready_t3", 32'(mready), 1);
    chk("mdu_we_t3", 32'(rf_we), 0);
    advance();
    mvalid = 0;
    settle();                              // t4
    chk("mdu_we_t4", 32'(rf_we), 1);
    chk("mdu_rd_t4", 32'(rf_rd), 8);
    chk("mdu_data_t4", rf_data, 32'hCAFE);
    chk("mdu_stall_t4", 32'(stall), 1);
    advance();
    settle();                              // t5
    chk("mdu_stall_t5", 32'(stall), 0);
    chk("mdu_we_t5", 32'(rf_we), 0);
    advance();
    idle_inputs();

    // Continuous WB traffic with three MDU results: third is backpressured.
    wb_we = 1; wb_rd = 3;
    for (int i = 0; i < 3; i++) begin
      wb_data = $urandom;
      mvalid = 1; mdest = 5'(10 + i); mdata = 32'hA000 + 32'(i);
      settle();
      chk("full_ready", 32'(mready), (i < 2) ? 1 : 0);
`ifdef REGFILE_ARB_FULL_STALL_EN
      if (i == 2) chk("full_stall", 32'(stall), 1);
`endif
      advance();
    end
    idle_inputs();
    settle();
    chk("drain0_rd", 32'(rf_rd), 10);
    chk("drain0_data", rf_data, 32'hA000);
    advance();
    settle();
    chk("drain1_rd", 32'(rf_rd), 11);
    chk("drain1_data", rf_data, 32'hA001);
    advance();
    settle();
    chk("drain2_we", 32'(rf_we), 0);
    advance();

    // Result to $0: accepted, never written.
    mvalid = 1; mdest = 0; mdata = 32'hDEAD;
    settle();
    chk("zero_ready", 32'(mready), 1);
    chk("zero_we", 32'(rf_we), 0);
    advance();
    idle_inputs();
    settle();
    chk("zero_we_next", 32'(rf_we), 0);
    advance();

    // Reset with two queued entries and pending[8].
    wb_we = 1; wb_rd = 4; wb_data = 32'h55;
    iss = 1; iss_dest = 8;
    mvalid = 1; mdest = 8; mdata = 32'h111;
    cycle();
    iss = 0; mdest = 9; mdata = 32'h222;
    cycle();
    mvalid = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    idle_inputs();
    ra1 = 8;
    settle();
    chk("rstq_we", 32'(rf_we), 0);
    chk("rstq_stall", 32'(stall), 0);
    chk("rstq_ready", 32'(mready), 1);
    advance();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      wb_we    = ($urandom_range(0, 99) < 55);
      wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_data  = $urandom;
      iss      = ($urandom_range(0, 99) < 30);
      iss_dest = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      mvalid   = ($urandom_range(0, 99) < 45);
      mdest    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      mdata    = $urandom;
      ra1      = 5'($urandom_range(0, 12));
      ra2      = 5'($urandom_range(0, 12));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
